// File: rtl/madd_pkg.sv
// madd_pkg: op bundle layout shared by every block that drives madd_pipeline.
// Bundle, LSB first: arg_a, arg_b, arg_c, shift(5), shift_disable, signedness,
// saturate_disable, dest(4), commit_id(9), commit_flag, block.
// The offset/width functions take the operand and block widths so that
// parameterised users can size their buses. op_t, OP_W and pack/unpack cover
// the default configuration (16-bit operands, 256 blocks).
package madd_pkg;

  localparam int unsigned SHIFT_W     = 5;
  localparam int unsigned DEST_W      = 4;
  localparam int unsigned COMMIT_ID_W = 9;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_BLOCK_W = 8;

  // Field offsets for an arbitrary operand width dw
  function automatic int unsigned off_arg_a(int unsigned dw);
    return 0 * dw;
  endfunction

  function automatic int unsigned off_arg_b(int unsigned dw);
    return 1 * dw;
  endfunction

  function automatic int unsigned off_arg_c(int unsigned dw);
    return 2 * dw;
  endfunction

  function automatic int unsigned off_shift(int unsigned dw);
    return 3 * dw;
  endfunction

  function automatic int unsigned off_shift_disable(int unsigned dw);
    return off_shift(dw) + SHIFT_W;
  endfunction

  function automatic int unsigned off_signedness(int unsigned dw);
    return off_shift_disable(dw) + 1;
  endfunction

  function automatic int unsigned off_saturate_disable(int unsigned dw);
    return off_signedness(dw) + 1;
  endfunction

  function automatic int unsigned off_dest(int unsigned dw);
    return off_saturate_disable(dw) + 1;
  endfunction

  function automatic int unsigned off_commit_id(int unsigned dw);
    return off_dest(dw) + DEST_W;
  endfunction

  function automatic int unsigned off_commit_flag(int unsigned dw);
    return off_commit_id(dw) + COMMIT_ID_W;
  endfunction

  function automatic int unsigned off_block(int unsigned dw);
    return off_commit_flag(dw) + 1;
  endfunction

  // Total bundle width for operand width dw and block-index width bw
  function automatic int unsigned op_width(int unsigned dw, int unsigned bw);
    return off_block(dw) + bw;
  endfunction

  // Default-configuration bundle; first member sits at the MSB end
  typedef struct packed {
    logic [DEF_BLOCK_W-1:0] block;
    logic                   commit_flag;
    logic [COMMIT_ID_W-1:0] commit_id;
    logic [DEST_W-1:0]      dest;
    logic                   saturate_disable;
    logic                   signedness;
    logic                   shift_disable;
    logic [SHIFT_W-1:0]     shift;
    logic [DEF_DATA_W-1:0]  arg_c;
    logic [DEF_DATA_W-1:0]  arg_b;
    logic [DEF_DATA_W-1:0]  arg_a;
  } op_t;

  localparam int unsigned OP_W = $bits(op_t);

  function automatic logic [OP_W-1:0] pack_op(op_t op);
    return OP_W'(op);
  endfunction

  function automatic op_t unpack_op(logic [OP_W-1:0] bits);
    return op_t'(bits);
  endfunction

endpackage

// File: rtl/madd_arbiter_tag_fifo.sv
// tag_fifo: in-order FIFO of requester tags, one entry per in-flight op.
// Ports: clk, reset (async, active-high), push/push_data, pop/head_data,
//        full, empty, count (occupancy, 0..depth).
// depth must be a power of two (>= 2); pointers wrap naturally mod depth.
module tag_fifo #(
  parameter int unsigned width = 2,
  parameter int unsigned depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [width-1:0]           push_data,
  input  logic                       pop,
  output logic [width-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth):0]     count
);

  localparam int unsigned AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (AW+1)'(depth));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage; contents are only observed while non-empty, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/madd_arbiter.sv
// madd_arbiter: shares one madd_pipeline between n_req requesters.
// One pending op per cycle is granted round-robin and registered into the
// pipeline input; the winner's index is queued in a tag FIFO so each result
// is steered back to its issuer in order.
// Ports:
//   clk, reset (async, active-high), enable (low blocks new grants)
//   req_valid/req_ready/req_op    : requester issue side, req_ready combinational
//   rsp_valid/rsp_ready/rsp_*     : requester result side, fields broadcast
//   madd_in_valid/ready, madd_op  : pipeline input (registered)
//   madd_out_valid/ready, madd_*  : pipeline output
//   inflight                      : tag FIFO occupancy
// Build option: MADD_ARB_PRIORITY_EN gives requester 0 strict priority; the
// others keep rotating among themselves.
module madd_arbiter
  import madd_pkg::*;
#(
  parameter int unsigned data_width   = 16,
  parameter int unsigned n_blocks     = 256,
  parameter int unsigned n_req        = 4,
  parameter int unsigned max_inflight = 8,
  localparam int unsigned BLK_W       = $clog2(n_blocks),
  localparam int unsigned TAG_W       = $clog2(n_req),
  localparam int unsigned CNT_W       = $clog2(max_inflight) + 1,
  localparam int unsigned ARB_OP_W    = op_width(data_width, BLK_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [n_req-1:0]          req_valid,
  output logic [n_req-1:0]          req_ready,
  input  logic [n_req*ARB_OP_W-1:0] req_op,
  output logic [n_req-1:0]          rsp_valid,
  input  logic [n_req-1:0]          rsp_ready,
  output logic [2*data_width-1:0]   rsp_result,
  output logic [DEST_W-1:0]         rsp_dest,
  output logic [COMMIT_ID_W-1:0]    rsp_commit_id,
  output logic                      rsp_commit_flag,
  output logic [BLK_W-1:0]          rsp_block,
  output logic                      madd_in_valid,
  input  logic                      madd_in_ready,
  output logic [ARB_OP_W-1:0]       madd_op,
  input  logic                      madd_out_valid,
  output logic                      madd_out_ready,
  input  logic [2*data_width-1:0]   madd_result,
  input  logic [DEST_W-1:0]         madd_dest,
  input  logic [COMMIT_ID_W-1:0]    madd_commit_id,
  input  logic                      madd_commit_flag,
  input  logic [BLK_W-1:0]          madd_block,
  output logic [CNT_W-1:0]          inflight
);

  logic                issue_valid;
  logic                issue_free;
  logic [TAG_W-1:0]    rr_ptr;
  logic [TAG_W-1:0]    rr_next;
  logic [TAG_W-1:0]    winner;
  logic                found;
  logic                grant;
  logic [ARB_OP_W-1:0] win_op;
  int unsigned         scan_idx;

  logic                fifo_full;
  logic                fifo_empty;
  logic [TAG_W-1:0]    head;
  logic                pop;

  assign issue_free = ~issue_valid | madd_in_ready;

  // Winner search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
`ifdef MADD_ARB_PRIORITY_EN
    if (req_valid[0]) found = 1'b1;
`endif
    for (int unsigned k = 0; k < n_req; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= n_req) scan_idx = scan_idx - n_req;
      if (!found && req_valid[TAG_W'(scan_idx)]) begin
        winner = TAG_W'(scan_idx);
        found  = 1'b1;
      end
    end
  end

  // Reset is folded in so req_ready stays low while reset is held
  assign grant = ~reset & enable & issue_free & ~fifo_full & found;

  assign rr_next = (winner == TAG_W'(n_req - 1)) ? '0 : winner + TAG_W'(1);

  // One-hot grant and op select
  always_comb begin
    req_ready = '0;
    win_op    = '0;
    if (grant) req_ready[winner] = 1'b1;
    for (int unsigned i = 0; i < n_req; i++) begin
      if (winner == TAG_W'(i)) win_op = req_op[i*ARB_OP_W +: ARB_OP_W];
    end
  end

  // Issue register and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid <= 1'b0;
      madd_op     <= '0;
      rr_ptr      <= '0;
    end else begin
      if (grant) begin
        issue_valid <= 1'b1;
        madd_op     <= win_op;
`ifdef MADD_ARB_PRIORITY_EN
        if (winner != '0) rr_ptr <= rr_next;
`else
        rr_ptr <= rr_next;
`endif
      end else if (madd_in_ready) begin
        issue_valid <= 1'b0;
      end
    end
  end

  assign madd_in_valid = issue_valid;

  tag_fifo #(
    .width (TAG_W),
    .depth (max_inflight)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant),
    .push_data (winner),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (inflight)
  );

  // Response steering; an empty FIFO keeps madd_out_ready low
  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < n_req; i++) begin
      rsp_valid[i] = madd_out_valid & ~fifo_empty & (head == TAG_W'(i));
    end
  end

  assign madd_out_ready = ~fifo_empty & rsp_ready[head];
  assign pop            = madd_out_valid & madd_out_ready;

  assign rsp_result      = madd_result;
  assign rsp_dest        = madd_dest;
  assign rsp_commit_id   = madd_commit_id;
  assign rsp_commit_flag = madd_commit_flag;
  assign rsp_block       = madd_block;

endmodule

// File: tb/tb_madd_arbiter.sv
// Directed bench for madd_arbiter at default parameters; the bench plays
// the requesters and the madd_pipeline handshakes.
module tb_madd_arbiter;
  import madd_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [4*OP_W-1:0]  req_op;
  logic [3:0]         rsp_valid;
  logic [3:0]         rsp_ready;
  logic [31:0]        rsp_result;
  logic [3:0]         rsp_dest;
  logic [8:0]         rsp_commit_id;
  logic               rsp_commit_flag;
  logic [7:0]         rsp_block;
  logic               madd_in_valid;
  logic               madd_in_ready;
  logic [OP_W-1:0]    madd_op;
  logic               madd_out_valid;
  logic               madd_out_ready;
  logic [31:0]        madd_result;
  logic [3:0]         madd_dest;
  logic [8:0]         madd_commit_id;
  logic               madd_commit_flag;
  logic [7:0]         madd_block;
  logic [3:0]         inflight;

  int checks   = 0;
  int failures = 0;

  logic [OP_W-1:0] ops [4];

  always #5 clk = ~clk;

  madd_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_dest         (rsp_dest),
    .rsp_commit_id    (rsp_commit_id),
    .rsp_commit_flag  (rsp_commit_flag),
    .rsp_block        (rsp_block),
    .madd_in_valid    (madd_in_valid),
    .madd_in_ready    (madd_in_ready),
    .madd_op          (madd_op),
    .madd_out_valid   (madd_out_valid),
    .madd_out_ready   (madd_out_ready),
    .madd_result      (madd_result),
    .madd_dest        (madd_dest),
    .madd_commit_id   (madd_commit_id),
    .madd_commit_flag (madd_commit_flag),
    .madd_block       (madd_block),
    .inflight         (inflight)
  );

  function automatic logic [OP_W-1:0] mk_op(logic [15:0] a, logic [15:0] b, logic [15:0] c,
                                            logic [4:0] sh, logic sgn, logic [3:0] dst,
                                            logic [8:0] cid, logic cf, logic [7:0] blk);
    op_t o;
    o = '0;
    o.arg_a = a; o.arg_b = b; o.arg_c = c; o.shift = sh; o.signedness = sgn;
    o.dest = dst; o.commit_id = cid; o.commit_flag = cf; o.block = blk;
    return pack_op(o);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_rr;
    for (int i = 0; i < 4; i++)
      ops[i] = mk_op(16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'h0300 + 16'(i),
                     5'(i), 1'b0, 4'(i), 9'(i), 1'b0, 8'(i));
    ops[2] = mk_op(16'h4000, 16'h2000, 16'h0010, 5'd14, 1'b1, 4'd5, 9'h123, 1'b1, 8'h42);
    req_op = {ops[3], ops[2], ops[1], ops[0]};

    // Reset state, with requests pending and a stray pipeline result
    reset = 1'b1; enable = 1'b1; req_valid = 4'hf; rsp_ready = 4'hf;
    madd_in_ready = 1'b1; madd_out_valid = 1'b1;
    madd_result = '0; madd_dest = '0; madd_commit_id = '0;
    madd_commit_flag = 1'b0; madd_block = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'h0);
    chk("rst_in_valid", 128'(madd_in_valid), 128'h0);
    chk("rst_madd_op", 128'(madd_op), 128'h0);
    chk("rst_inflight", 128'(inflight), 128'h0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'h0);
    chk("rst_out_ready", 128'(madd_out_ready), 128'h0);
    madd_out_valid = 1'b0; req_valid = 4'h0; reset = 1'b0;
    tick();

    // Single requester 2
    req_valid = 4'b0100;
    #1 chk("single_grant", 128'(req_ready), 128'h4);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single_in_valid", 128'(madd_in_valid), 128'h1);
    chk("single_op", 128'(madd_op), 128'(ops[2]));
    chk("single_inflight", 128'(inflight), 128'h1);
    chk("single_no_regrant", 128'(req_ready), 128'h0);
    tick();
    #1 chk("single_in_valid_clr", 128'(madd_in_valid), 128'h0);
    madd_out_valid = 1'b1; madd_result = 32'h0000_1010; madd_dest = 4'd5;
    madd_commit_id = 9'h123; madd_commit_flag = 1'b1; madd_block = 8'h42;
    #1;
    chk("single_rsp_valid", 128'(rsp_valid), 128'h4);
    chk("single_out_ready", 128'(madd_out_ready), 128'h1);
    chk("single_rsp_result", 128'(rsp_result), 128'h1010);
    chk("single_rsp_cid", 128'(rsp_commit_id), 128'h123);
    chk("single_rsp_block", 128'(rsp_block), 128'h42);
    tick();
    madd_out_valid = 1'b0;
    #1 chk("single_popped", 128'(inflight), 128'h0);

    // Async reset pulse to bring rr_ptr back to 0
    reset = 1'b1;
    #1 reset = 1'b0;
    tick();

`ifndef MADD_ARB_PRIORITY_EN
    // Round-robin fill with no pops until the FIFO is full
    rsp_ready = 4'h0; req_valid = 4'hf;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_grant", 128'(req_ready), 128'(4'b0001 << (k % 4)));
      if (k > 0) begin
        chk("rr_op", 128'(madd_op), 128'(ops[(k - 1) % 4]));
        chk("rr_inflight", 128'(inflight), 128'(k));
      end
      tick();
    end
    #1;
    chk("full_no_grant", 128'(req_ready), 128'h0);
    chk("full_inflight", 128'(inflight), 128'h8);
    chk("full_last_op", 128'(madd_op), 128'(ops[3]));
    madd_out_valid = 1'b1;
    #1;
    chk("full_rsp_head0", 128'(rsp_valid), 128'h1);
    chk("full_blocked_out", 128'(madd_out_ready), 128'h0);
    tick();
    rsp_ready = 4'b0001;
    #1;
    chk("full_pop_ready", 128'(madd_out_ready), 128'h1);
    chk("full_pop_no_grant", 128'(req_ready), 128'h0);
    tick();
    rsp_ready = 4'h0;
    #1;
    chk("after_pop_inflight", 128'(inflight), 128'h7);
    chk("after_pop_grant", 128'(req_ready), 128'h1);
    tick();
    #1 chk("refill_inflight", 128'(inflight), 128'h8);
    // Drain: responses follow grant order
    req_valid = 4'h0; rsp_ready = 4'hf;
    for (int j = 0; j < 8; j++) begin
      #1 chk("drain_order", 128'(rsp_valid), 128'(4'b0001 << ((j + 1) % 4)));
      tick();
    end
    #1;
    chk("drain_empty", 128'(inflight), 128'h0);
    chk("empty_out_ready", 128'(madd_out_ready), 128'h0);
    chk("empty_rsp_valid", 128'(rsp_valid), 128'h0);
    madd_out_valid = 1'b0;
`else
    // Requester 0 wins every cycle while valid, then requester 1
    rsp_ready = 4'h0; req_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      #1 chk("prio_r0", 128'(req_ready), 128'h1);
      tick();
    end
    req_valid = 4'b0010;
    #1 chk("prio_r1", 128'(req_ready), 128'h2);
    tick();
    req_valid = 4'h0;
    reset = 1'b1;
    #1 reset = 1'b0;
`endif
    reset = 1'b1;
    #1 reset = 1'b0;
    tick();

    // Backpressure: grant requester 1, then stall the pipeline input
    rsp_ready = 4'h0; madd_in_ready = 1'b1; req_valid = 4'b0010;
    #1 chk("bp_first_grant", 128'(req_ready), 128'h2);
    tick();
    madd_in_ready = 1'b0; req_valid = 4'hf;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_no_grant", 128'(req_ready), 128'h0);
      chk("bp_op_stable", 128'(madd_op), 128'(ops[1]));
      chk("bp_in_valid", 128'(madd_in_valid), 128'h1);
      tick();
    end
    madd_in_ready = 1'b1;
`ifdef MADD_ARB_PRIORITY_EN
    exp_rr = 4'b0001;
`else
    exp_rr = 4'b0100;
`endif
    #1 chk("bp_release_grant", 128'(req_ready), 128'(exp_rr));
    tick();
    #1 chk("bp_inflight", 128'(inflight), 128'h2);

    // Enable low: no grant, pending issue held
    enable = 1'b0; madd_in_ready = 1'b0;
    #1 chk("en_low_no_grant", 128'(req_ready), 128'h0);
    tick();
    #1;
    chk("en_low_hold_valid", 128'(madd_in_valid), 128'h1);
    chk("en_low_inflight", 128'(inflight), 128'h2);
    enable = 1'b1; madd_in_ready = 1'b1;
`ifdef MADD_ARB_PRIORITY_EN
    exp_rr = 4'b0001;
`else
    exp_rr = 4'b1000;
`endif
    #1 chk("en_high_grant", 128'(req_ready), 128'(exp_rr));
    tick();
    #1 chk("pre_rst_inflight", 128'(inflight), 128'h3);

    // Asynchronous reset mid-burst with 3 ops in flight
    madd_out_valid = 1'b1; rsp_ready = 4'hf;
    #2 reset = 1'b1;
    #1;
    chk("arst_in_valid", 128'(madd_in_valid), 128'h0);
    chk("arst_req_ready", 128'(req_ready), 128'h0);
    chk("arst_rsp_valid", 128'(rsp_valid), 128'h0);
    chk("arst_out_ready", 128'(madd_out_ready), 128'h0);
    chk("arst_madd_op", 128'(madd_op), 128'h0);
    chk("arst_inflight", 128'(inflight), 128'h0);
    tick();
    reset = 1'b0; madd_out_valid = 1'b0;
    #1 chk("post_rst_grant", 128'(req_ready), 128'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
